// File: rtl/data_sram_if.sv
// Data SRAM-like request/response bundle between the CPU (master) and the
// memory-side responder (slave).
interface data_sram_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Slave end of the CPU data SRAM port: byte-writable word RAM plus a small
// configuration register bank (timer, LEDs, switches, number display).
module data_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [15:0] CONF_HI    = 16'hBFAF
) (
    input  logic             clk,
    input  logic             resetn,
    data_sram_if.slave       data_sram,
    input  logic [7:0]       switch,
    output logic [15:0]      led,
    output logic [31:0]      num_data
);

    localparam logic [15:0] OFF_TIMER  = 16'hE000;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_SWITCH = 16'hF004;
    localparam logic [15:0] OFF_NUM    = 16'hF010;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [31:0]           timer;
    logic [7:0]            switch_meta;
    logic [7:0]            switch_sync;

    logic                  conf_hit;
    logic [15:0]           offset;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  wr;
    logic                  wr_timer;
    logic                  wr_led;
    logic                  wr_num;
    logic                  wr_ram;
    logic [31:0]           conf_rdata;
    logic [31:0]           led_merged;

    // Lane-wise merge: enabled lanes take new data, the rest keep old.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        conf_hit = (data_sram.addr[31:16] == CONF_HI);
        offset   = data_sram.addr[15:0];
        ram_idx  = data_sram.addr[ADDR_WIDTH+1:2];
        wr       = data_sram.en && (data_sram.wen != 4'b0000);
        wr_timer = wr && conf_hit && (offset == OFF_TIMER);
        wr_led   = wr && conf_hit && (offset == OFF_LED);
        wr_num   = wr && conf_hit && (offset == OFF_NUM);
        wr_ram   = wr && !conf_hit;
    end

    always_comb begin
        conf_rdata = '0;
        case (offset)
            OFF_TIMER:  conf_rdata = timer;
            OFF_LED:    conf_rdata = {16'h0000, led};
            OFF_SWITCH: conf_rdata = {24'h000000, switch_sync};
            OFF_NUM:    conf_rdata = num_data;
            default:    conf_rdata = '0;
        endcase
    end

    always_comb begin
        led_merged = merge_lanes({16'h0000, led}, data_sram.wdata, data_sram.wen);
    end

    // A timer write replaces the increment for that cycle only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
        end else if (wr_timer) begin
            timer <= merge_lanes(timer, data_sram.wdata, data_sram.wen);
        end else begin
            timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led      <= '0;
            num_data <= '0;
        end else begin
            if (wr_led) begin
                led <= led_merged[15:0];
            end
            if (wr_num) begin
                num_data <= merge_lanes(num_data, data_sram.wdata, data_sram.wen);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            switch_meta <= '0;
            switch_sync <= '0;
        end else begin
            switch_meta <= switch;
            switch_sync <= switch_meta;
        end
    end

    // Read-first: writes also return the pre-write word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram.rdata <= '0;
        end else if (data_sram.en) begin
            data_sram.rdata <= conf_hit ? conf_rdata : mem[ram_idx];
        end
    end

    // RAM is not reset; the resetn gate drops a write caught by reset.
    always_ff @(posedge clk) begin
        if (resetn && wr_ram) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_sram.wen[i]) begin
                    mem[ram_idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;
    int          tests;
    int          fails;

    data_sram_if bus();

    data_sram_responder #(
        .ADDR_WIDTH(10),
        .CONF_HI   (16'hBFAF)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .data_sram(bus),
        .switch   (switch),
        .led      (led),
        .num_data (num_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, let it be sampled at the next edge, settle 1 time unit.
    task automatic req(input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
        bus.en    = e;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.en  = 1'b0;
        bus.wen = 4'h0;
    endtask

    task automatic test_reset;
        tests++;
        if (bus.rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'h0);
        end
        tests++;
        if (led !== 16'h0) begin
            fails++; $display("FAIL reset_led: got %h want %h", led, 16'h0);
        end
        tests++;
        if (num_data !== 32'h0) begin
            fails++; $display("FAIL reset_num: got %h want %h", num_data, 32'h0);
        end
    endtask

    task automatic test_config;
        req(1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_5678);
        tests++;
        if (led !== 16'h5678) begin
            fails++; $display("FAIL led_write: got %h want %h", led, 16'h5678);
        end
        req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        tests++;
        if (bus.rdata !== 32'h0000_5678) begin
            fails++; $display("FAIL led_read: got %h want %h", bus.rdata, 32'h0000_5678);
        end
        req(1'b1, 4'hF, 32'hBFAF_F010, 32'hCAFE_BABE);
        tests++;
        if (num_data !== 32'hCAFE_BABE) begin
            fails++; $display("FAIL num_write: got %h want %h", num_data, 32'hCAFE_BABE);
        end
        req(1'b1, 4'b1000, 32'hBFAF_F010, 32'h1100_0000);
        tests++;
        if (num_data !== 32'h11FE_BABE) begin
            fails++; $display("FAIL num_byte: got %h want %h", num_data, 32'h11FE_BABE);
        end
        req(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
        tests++;
        if (bus.rdata !== 32'h11FE_BABE) begin
            fails++; $display("FAIL num_read: got %h want %h", bus.rdata, 32'h11FE_BABE);
        end
        req(1'b1, 4'h0, 32'hBFAF_F0FC, 32'h0);
        tests++;
        if (bus.rdata !== 32'h0) begin
            fails++; $display("FAIL unmapped_read: got %h want %h", bus.rdata, 32'h0);
        end
    endtask

    task automatic test_async_reset;
        req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        tests++;
        if (bus.rdata !== 32'h0000_5678) begin
            fails++; $display("FAIL pre_reset_rdata: got %h want %h", bus.rdata, 32'h0000_5678);
        end
        #3 resetn = 1'b0;
        #1;
        test_reset;
        #2 resetn = 1'b1;
        req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests++;
        if (bus.rdata !== 32'h0) begin
            fails++; $display("FAIL timer_after_reset0: got %h want %h", bus.rdata, 32'h0);
        end
        req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        tests++;
        if (bus.rdata !== 32'h1) begin
            fails++; $display("FAIL timer_after_reset1: got %h want %h", bus.rdata, 32'h1);
        end
    endtask

    task automatic test_ram;
        req(1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
        req(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
        req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tests++;
        if (bus.rdata !== 32'h11BB_33DD) begin
            fails++; $display("FAIL ram_byte_write: got %h want %h", bus.rdata, 32'h11BB_33DD);
        end
        req(1'b1, 4'hF, 32'h0000_1010, 32'hDEAD_BEEF);
        tests++;
        if (bus.rdata !== 32'h11BB_33DD) begin
            fails++; $display("FAIL ram_read_first: got %h want %h", bus.rdata, 32'h11BB_33DD);
        end
        req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tests++;
        if (bus.rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL ram_alias: got %h want %h", bus.rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_idle;
        req(1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000);
        tests++;
        if (bus.rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL idle_hold: got %h want %h", bus.rdata, 32'hDEAD_BEEF);
        end
        req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tests++;
        if (bus.rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL idle_no_write: got %h want %h", bus.rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_timer;
        logic [31:0] exp_t [3];
        exp_t[0] = 32'hFFFF_FFFE;
        exp_t[1] = 32'hFFFF_FFFF;
        exp_t[2] = 32'h0000_0000;
        req(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
            tests++;
            if (bus.rdata !== exp_t[i]) begin
                fails++; $display("FAIL timer_read%0d: got %h want %h", i, bus.rdata, exp_t[i]);
            end
        end
    endtask

    task automatic test_switch;
        logic [31:0] exp_s [3];
        exp_s[0] = 32'h0;
        exp_s[1] = 32'h0;
        exp_s[2] = 32'h0000_00A5;
        switch = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
            tests++;
            if (bus.rdata !== exp_s[i]) begin
                fails++; $display("FAIL switch_edge%0d: got %h want %h", i + 1, bus.rdata, exp_s[i]);
            end
        end
        req(1'b1, 4'hF, 32'hBFAF_F004, 32'hFFFF_FFFF);
        req(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
        tests++;
        if (bus.rdata !== 32'h0000_00A5) begin
            fails++; $display("FAIL switch_write_ignored: got %h want %h", bus.rdata, 32'h0000_00A5);
        end
        tests++;
        if (led !== 16'h0000) begin
            fails++; $display("FAIL switch_led_untouched: got %h want %h", led, 16'h0000);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        resetn    = 1'b0;
        switch    = 8'h00;
        bus.en    = 1'b0;
        bus.wen   = 4'h0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        resetn = 1'b1;
        test_config;
        test_async_reset;
        test_ram;
        test_idle;
        test_timer;
        test_switch;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
